ula_ops_ctrl: RTL
=================

# ula_ops_ctrl

Sequencer for the ULA datapath block of the pamPy bytecode processor. It accepts one Python bytecode operation at a time (opcode plus argument) over a valid/ready handshake and decodes it. It then drives the operand-mux selects, operand-register loads and ULA function select of the ULA datapath over a fixed cycle schedule. When the operation completes, it samples the datapath's registered compare and overflow flags and returns them with a single-cycle completion pulse.

## Interface
- DATA_WIDTH, 8, opcode/argument width
- MUL_LATENCY, 3, EXEC cycles held for multiply (≥1); all other ops hold EXEC 1 cycle
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- op_valid  in  1  opcode/arg presented
- op_ready  out  1  controller can accept; transfer when op_valid & op_ready
- opcode  in  DATA_WIDTH  Python bytecode opcode
- arg  in  DATA_WIDTH  bytecode argument (compare selector for COMPARE_OP)
- comp_in  in  1  datapath REG_COMP_OUT
- ovf_in  in  1  datapath REG_OVERFLOW_OUT
- SEL_MUX1  out  2  op1 mux: 0 stack data, 1 regJump
- SEL_MUX2  out  2  op2 mux: 0 regArg, 1 tos, 2 pc
- CTRL_REG_OP1 / CTRL_REG_OP2  out  1 each  operand register load enables
- SEL_ULA  out  4  ULA function
- res_valid  out  1  one-cycle completion pulse
- res_comp / res_ovf  out  1 each  flags of last completed op, held until next completion
- op_err  out  1  one-cycle pulse on unsupported opcode or COMPARE_OP arg > 5

## Operation
- States: IDLE, LOAD, EXEC, DONE.
- IDLE: op_ready=1, all controls 0. On handshake, register the decoded SEL_ULA and the multiply flag.
  - Valid op → LOAD.
  - Invalid op → op_err pulse next cycle; stay IDLE with op_ready=0 for that one cycle.
- LOAD (1 cycle): CTRL_REG_OP1=1, CTRL_REG_OP2=1, SEL_MUX1=0, SEL_MUX2=1 (op1=TOS1, op2=TOS) → EXEC.
- EXEC: SEL_ULA held at the decoded function, load enables 0.
  - Down-counter loaded with MUL_LATENCY-1 (multiply) or 0 (otherwise).
  - Move to DONE when the counter reaches 0.
- DONE (1 cycle): res_valid=1; res_comp←comp_in, res_ovf←ovf_in; SEL_ULA still held → IDLE.
- Decode, opcode→SEL_ULA:
  - 23 BINARY_ADD / 55 INPLACE_ADD → 0 ADD
  - 24 / 56 → 1 SUB
  - 20 / 57 → 2 MUL
  - 64 → 3 AND
  - 66 → 4 OR
  - 65 → 5 XOR
  - 107 COMPARE_OP → 6+arg (6 LT, 7 LE, 8 EQ, 9 NE, 10 GT, 11 GE)
  - all others invalid
- SEL_ULA values 12–15 are reserved and never driven.
- op_err and res_valid are never asserted in the same cycle.

## Timing
- Reset values: op_ready=1, all mux/load/SEL_ULA outputs 0, res_valid=0, res_comp=0, res_ovf=0, op_err=0, state IDLE, counter 0.
- Latency, handshake to res_valid: 3 cycles for non-multiply ops, 2+MUL_LATENCY for multiply.
- Throughput: one op per 4 cycles for non-multiply, since IDLE is revisited.
- op_ready is 0 in LOAD/EXEC/DONE. op_valid during those states is ignored; opcode/arg need not be held after the handshake.
- Reset in any state: the next cycle is IDLE with reset values, an in-flight op is dropped, and no res_valid is issued.
- MUL_LATENCY=1: multiply behaves exactly like any other op.
- op_valid held high continuously: the next op is accepted in the IDLE cycle after DONE, and in the IDLE cycle after an error.

## Structure
- Package `pampy_ops_pkg` holds:
  - opcode localparams (ADD=23, …, COMPARE_OP=107)
  - SEL_ULA encoding constants (0–11)
  - mux-select constants
  - state enum
  The ULA datapath shares this package.
- Sub-module `ula_op_decoder`: combinational opcode/arg → {valid, sel_ula, is_mul}. The FSM and counter stay in ula_ops_ctrl.

## Test plan
- Reset then opcode=23, arg=0 → CTRL_REG_OP1/OP2=1, SEL_MUX2=1 at +1; SEL_ULA=0 at +2; res_valid at +3 with res_comp/res_ovf equal to comp_in/ovf_in forced to 1/0.
- opcode=20 with MUL_LATENCY=3 → SEL_ULA=2 held for 3 EXEC cycles; res_valid at +5; repeat with MUL_LATENCY=1 → res_valid at +3.
- opcode=107 for each arg 0..5 → SEL_ULA 6..11; arg=6 → op_err pulse, no res_valid, next op accepted 2 cycles after the handshake.
- opcode=99 (unsupported) → op_err single pulse, all controls remain 0.
- Back-to-back op_valid high with ops 24, 64, 57 → accepted every 4th cycle except 57 (6 cycles with default MUL_LATENCY); res_ovf updated only on each res_valid.
- reset asserted during EXEC of a multiply → next cycle all outputs at reset values, no res_valid; fresh op completes normally afterward.

Source files
------------

// File: rtl/pampy_ops_pkg.sv
// -----------------------------------------------------------------------------
// pampy_ops_pkg
// Shared definitions for the pamPy ULA datapath and its sequencer:
//   - Python bytecode opcodes handled by the ULA
//   - SEL_ULA function encodings (0..11; 12..15 reserved)
//   - operand-mux select encodings
//   - sequencer state enum and decoded-operation struct
// -----------------------------------------------------------------------------
package pampy_ops_pkg;

  // Python bytecode opcodes
  localparam int unsigned OP_BINARY_MULTIPLY  = 20;
  localparam int unsigned OP_BINARY_ADD       = 23;
  localparam int unsigned OP_BINARY_SUBTRACT  = 24;
  localparam int unsigned OP_INPLACE_ADD      = 55;
  localparam int unsigned OP_INPLACE_SUBTRACT = 56;
  localparam int unsigned OP_INPLACE_MULTIPLY = 57;
  localparam int unsigned OP_BINARY_AND       = 64;
  localparam int unsigned OP_BINARY_XOR       = 65;
  localparam int unsigned OP_BINARY_OR        = 66;
  localparam int unsigned OP_COMPARE_OP       = 107;

  // Highest COMPARE_OP selector the ULA implements (GE)
  localparam int unsigned CMP_ARG_MAX = 5;

  // ULA function select
  localparam logic [3:0] ULA_ADD = 4'd0;
  localparam logic [3:0] ULA_SUB = 4'd1;
  localparam logic [3:0] ULA_MUL = 4'd2;
  localparam logic [3:0] ULA_AND = 4'd3;
  localparam logic [3:0] ULA_OR  = 4'd4;
  localparam logic [3:0] ULA_XOR = 4'd5;
  localparam logic [3:0] ULA_LT  = 4'd6;
  localparam logic [3:0] ULA_LE  = 4'd7;
  localparam logic [3:0] ULA_EQ  = 4'd8;
  localparam logic [3:0] ULA_NE  = 4'd9;
  localparam logic [3:0] ULA_GT  = 4'd10;
  localparam logic [3:0] ULA_GE  = 4'd11;

  // Operand mux selects
  localparam logic [1:0] MUX1_STACK   = 2'd0;
  localparam logic [1:0] MUX1_REGJUMP = 2'd1;
  localparam logic [1:0] MUX2_REGARG  = 2'd0;
  localparam logic [1:0] MUX2_TOS     = 2'd1;
  localparam logic [1:0] MUX2_PC      = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] sel_ula;
    logic       is_mul;
  } op_dec_t;

endpackage

// File: rtl/ula_ops_ctrl_if.sv
// -----------------------------------------------------------------------------
// ula_ops_ctrl_if
// Operation request / completion bundle of the ULA sequencer.
//   op_valid/op_ready/opcode/arg : request handshake (master -> slave)
//   res_valid/res_comp/res_ovf   : completion pulse and returned flags
//   op_err                       : rejected-operation pulse
// master = issuing side, slave = ula_ops_ctrl.
// -----------------------------------------------------------------------------
interface ula_ops_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  op_valid;
  logic                  op_ready;
  logic [DATA_WIDTH-1:0] opcode;
  logic [DATA_WIDTH-1:0] arg;
  logic                  res_valid;
  logic                  res_comp;
  logic                  res_ovf;
  logic                  op_err;

  modport master (
    output op_valid, opcode, arg,
    input  op_ready, res_valid, res_comp, res_ovf, op_err
  );

  modport slave (
    input  op_valid, opcode, arg,
    output op_ready, res_valid, res_comp, res_ovf, op_err
  );
endinterface

// File: rtl/ula_op_decoder.sv
// -----------------------------------------------------------------------------
// ula_op_decoder
// Combinational decode of a bytecode opcode/argument into the ULA function.
//   opcode, arg : bytecode operation
//   dec         : {valid, sel_ula, is_mul}; sel_ula is 0 when not valid
// -----------------------------------------------------------------------------
module ula_op_decoder
  import pampy_ops_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] opcode,
  input  logic [DATA_WIDTH-1:0] arg,
  output op_dec_t               dec
);

  logic [31:0] opc;
  logic [31:0] argv;

  always_comb begin
    opc  = 32'(opcode);
    argv = 32'(arg);
    // NOTE: every output of a combinational block gets a default before the
    // case statement; a path that leaves it unassigned would infer a latch.
    dec  = '0;
    case (opc)
      OP_BINARY_ADD, OP_INPLACE_ADD: begin
        dec.valid   = 1'b1;
        dec.sel_ula = ULA_ADD;
      end
      OP_BINARY_SUBTRACT, OP_INPLACE_SUBTRACT: begin
        dec.valid   = 1'b1;
        dec.sel_ula = ULA_SUB;
      end
      OP_BINARY_MULTIPLY, OP_INPLACE_MULTIPLY: begin
        dec.valid   = 1'b1;
        dec.sel_ula = ULA_MUL;
        dec.is_mul  = 1'b1;
      end
      OP_BINARY_AND: begin
        dec.valid   = 1'b1;
        dec.sel_ula = ULA_AND;
      end
      OP_BINARY_OR: begin
        dec.valid   = 1'b1;
        dec.sel_ula = ULA_OR;
      end
      OP_BINARY_XOR: begin
        dec.valid   = 1'b1;
        dec.sel_ula = ULA_XOR;
      end
      OP_COMPARE_OP: begin
        // Compare functions are laid out contiguously from LT, so the
        // selector is an offset; anything past GE would hit reserved codes.
        if (argv <= CMP_ARG_MAX) begin
          dec.valid   = 1'b1;
          dec.sel_ula = ULA_LT + 4'(argv);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ula_ops_ctrl.sv
// -----------------------------------------------------------------------------
// ula_ops_ctrl
// Sequencer for the pamPy ULA datapath. Accepts one bytecode op, loads the
// operand registers (op1 = TOS1, op2 = TOS), holds the ULA function for the
// execute phase (MUL_LATENCY cycles for multiply, 1 otherwise), then returns
// the datapath compare/overflow flags with a one-cycle res_valid.
//   clk, reset     : clock, synchronous active-high reset
//   op_if (slave)  : request handshake, completion and error pulses
//   comp_in/ovf_in : registered flags from the datapath
//   SEL_MUX1/2, CTRL_REG_OP1/2, SEL_ULA : datapath controls
// -----------------------------------------------------------------------------
module ula_ops_ctrl
  import pampy_ops_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int MUL_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  ula_ops_ctrl_if.slave        op_if,
  input  logic                 comp_in,
  input  logic                 ovf_in,
  output logic [1:0]           SEL_MUX1,
  output logic [1:0]           SEL_MUX2,
  output logic                 CTRL_REG_OP1,
  output logic                 CTRL_REG_OP2,
  output logic [3:0]           SEL_ULA
);

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sel_q;
  logic             is_mul_q;
  logic             err_q;
  logic             comp_q, ovf_q;
  logic             accept;
  op_dec_t          dec;

  ula_op_decoder #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .opcode (op_if.opcode),
    .arg    (op_if.arg),
    .dec    (dec)
  );

  // Built from registered state rather than op_ready to avoid a
  // combinational loop through the output block.
  assign accept = op_if.op_valid && (state_q == ST_IDLE) && !err_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sel_q    <= ULA_ADD;
      is_mul_q <= 1'b0;
      err_q    <= 1'b0;
      comp_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Rejected op: one IDLE cycle with op_err high and op_ready low.
      err_q   <= accept && !dec.valid;
      if (accept) begin
        sel_q    <= dec.sel_ula;
        is_mul_q <= dec.is_mul;
      end
      if (state_q == ST_DONE) begin
        comp_q <= comp_in;
        ovf_q  <= ovf_in;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    op_if.op_ready  = 1'b0;
    op_if.res_valid = 1'b0;
    SEL_MUX1        = MUX1_STACK;
    SEL_MUX2        = MUX2_REGARG;
    CTRL_REG_OP1    = 1'b0;
    CTRL_REG_OP2    = 1'b0;
    SEL_ULA         = ULA_ADD;
    case (state_q)
      ST_IDLE: begin
        op_if.op_ready = !err_q;
        if (accept && dec.valid) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        CTRL_REG_OP1 = 1'b1;
        CTRL_REG_OP2 = 1'b1;
        SEL_MUX1     = MUX1_STACK;
        SEL_MUX2     = MUX2_TOS;
        cnt_d        = is_mul_q ? CNT_W'(MUL_LATENCY - 1) : '0;
        state_d      = ST_EXEC;
      end
      ST_EXEC: begin
        SEL_ULA = sel_q;
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: begin
        SEL_ULA         = sel_q;
        op_if.res_valid = 1'b1;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Flags pass straight through while res_valid is high so they accompany
  // the pulse; the captured copy holds them until the next completion.
  assign op_if.res_comp = (state_q == ST_DONE) ? comp_in : comp_q;
  assign op_if.res_ovf  = (state_q == ST_DONE) ? ovf_in  : ovf_q;
  assign op_if.op_err   = err_q;

endmodule
